wt_dcache_rrip_repl: RTL and testbench

WT_DCACHE_RRIP_REPL -- requirements
Module: wt_dcache_rrip_repl

---
 rtl/wt_dcache_rrip_repl.sv | 195 +++++++++++++++++++
 tb/tb_wt_dcache_rrip_repl.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wt_dcache_rrip_repl.sv
// ---------------------------------------------------------------------------
// wt_dcache_rrip_repl
//
// RRIP victim selector for a set-associative write-through data cache.
// Every (set, way) pair holds a 2-bit re-reference prediction value (RRPV):
// 3 means the line is predicted to be re-used far in the future, and
// 0 means it is predicted to be re-used soon.
//
// When a miss needs a victim, the block looks for a way of the missing set
// with RRPV 3. If there is none, every way of that set is aged by one step
// and the search is repeated. The chosen way is reported and then refilled
// with an insertion RRPV that comes from the signature predictor.
//
// Ports
//   clk_i          clock; all state changes on the rising edge
//   rst_i          asynchronous, active-high reset
//   flush_i        synchronous flush: all RRPVs go to 3 and any request is dropped
//   hit_valid_i    hit strobe; the RRPV at hit_idx_i/hit_way_i becomes 0
//   hit_idx_i      set index of the hit
//   hit_way_i      way of the hit
//   miss_valid_i   victim request
//   miss_ready_o   high while idle; a request is accepted when valid && ready
//   miss_idx_i     set index of the miss
//   pred_result_i  predictor counter for the missing line (0 means distant insert)
//   victim_valid_o one-cycle pulse: the victim below is valid
//   victim_idx_o   set index of the last victim; held until the next victim
//   victim_way_o   way of the last victim; held until the next victim
//   busy_o         a request is in flight
// ---------------------------------------------------------------------------
module wt_dcache_rrip_repl #(
  parameter int unsigned NumSets = 256,
  parameter int unsigned NumWays = 4,
  localparam int unsigned IdxW   = $clog2(NumSets),
  localparam int unsigned WayW   = $clog2(NumWays)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            hit_valid_i,
  input  logic [IdxW-1:0] hit_idx_i,
  input  logic [WayW-1:0] hit_way_i,
  input  logic            miss_valid_i,
  output logic            miss_ready_o,
  input  logic [IdxW-1:0] miss_idx_i,
  input  logic [1:0]      pred_result_i,
  output logic            victim_valid_o,
  output logic [IdxW-1:0] victim_idx_o,
  output logic [WayW-1:0] victim_way_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    RESP
  } state_e;

  state_e          state_q, state_d;

  logic [1:0]      rrpv_q [NumSets][NumWays];

  logic [IdxW-1:0] req_idx_q;
  logic [1:0]      req_pred_q;
  logic [WayW-1:0] sel_way_q;

  logic            any_distant;
  logic [WayW-1:0] first_distant;
  logic [1:0]      insert_rrpv;
  logic            accept;
  logic            respond;

  assign accept      = (state_q == IDLE) && miss_valid_i;
  assign respond     = (state_q == RESP) && !flush_i;
  // A predictor counter of 0 means the line has shown no reuse, so it is
  // inserted as distant and becomes the first candidate for the next eviction.
  assign insert_rrpv = (req_pred_q == 2'd0) ? 2'd3 : 2'd2;

  // Find the lowest-numbered way of the set under search whose RRPV is 3.
  // The loop runs from the top way down so that the lowest match is kept.
  always_comb begin
    any_distant   = 1'b0;
    first_distant = '0;
    for (int w = int'(NumWays) - 1; w >= 0; w--) begin
      if (rrpv_q[req_idx_q][w] == 2'd3) begin
        any_distant   = 1'b1;
        first_distant = WayW'(w);
      end
    end
  end

  // State register. Reset is asynchronous, so an in-flight request is
  // dropped at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. SEARCH repeats while no way of the set is distant;
  // each repetition ages the set, so at most three repetitions occur.
  // A flush drops the request in any state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (miss_valid_i) state_d = SEARCH;
      SEARCH:  if (any_distant)  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // Handshake outputs depend only on the state.
  always_comb begin
    miss_ready_o = 1'b0;
    busy_o       = 1'b1;
    if (state_q == IDLE) begin
      miss_ready_o = 1'b1;
      busy_o       = 1'b0;
    end
  end

  // Request registers. The set and the predictor value are captured on
  // acceptance. The victim way is captured when the search ends, so a hit
  // that arrives while in RESP cannot change which way is reported.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_idx_q  <= '0;
      req_pred_q <= '0;
      sel_way_q  <= '0;
    end else begin
      if (accept) begin
        req_idx_q  <= miss_idx_i;
        req_pred_q <= pred_result_i;
      end
      if ((state_q == SEARCH) && any_distant) begin
        sel_way_q <= first_distant;
      end
    end
  end

  // Victim result. The outputs are registered, so the pulse appears in the
  // cycle after RESP. The index and way are kept until the next victim.
  // A flush in RESP cancels the pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      victim_valid_o <= 1'b0;
      victim_idx_o   <= '0;
      victim_way_o   <= '0;
    end else begin
      victim_valid_o <= respond;
      if (respond) begin
        victim_idx_o <= req_idx_q;
        victim_way_o <= sel_way_q;
      end
    end
  end

  // RRPV array. The writes are ordered so that the last non-blocking
  // assignment wins: set-wide aging first, then a hit (a hit beats aging on
  // the same way), then the victim insertion (insertion beats a hit on the
  // same way). A flush overrides all three writes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < int'(NumSets); s++) begin
        for (int w = 0; w < int'(NumWays); w++) begin
          rrpv_q[s][w] <= 2'd3;
        end
      end
    end else if (flush_i) begin
      for (int s = 0; s < int'(NumSets); s++) begin
        for (int w = 0; w < int'(NumWays); w++) begin
          rrpv_q[s][w] <= 2'd3;
        end
      end
    end else begin
      if ((state_q == SEARCH) && !any_distant) begin
        for (int w = 0; w < int'(NumWays); w++) begin
          if (rrpv_q[req_idx_q][w] != 2'd3) begin
            rrpv_q[req_idx_q][w] <= rrpv_q[req_idx_q][w] + 2'd1;
          end
        end
      end
      if (hit_valid_i) begin
        rrpv_q[hit_idx_i][hit_way_i] <= 2'd0;
      end
      if (state_q == RESP) begin
        rrpv_q[req_idx_q][sel_way_q] <= insert_rrpv;
      end
    end
  end

endmodule

// File: tb/tb_wt_dcache_rrip_repl.sv
// ---------------------------------------------------------------------------
// tb_wt_dcache_rrip_repl
//
// Directed testbench for wt_dcache_rrip_repl with the default parameters
// (256 sets, 4 ways). Each task drives one scenario and compares the DUT
// against values worked out by hand. The tasks run in sequence, and the
// RRPV state one scenario leaves behind is the starting point of the next.
// ---------------------------------------------------------------------------
module tb_wt_dcache_rrip_repl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       flush_i;
  logic       hit_valid_i;
  logic [7:0] hit_idx_i;
  logic [1:0] hit_way_i;
  logic       miss_valid_i;
  logic       miss_ready_o;
  logic [7:0] miss_idx_i;
  logic [1:0] pred_result_i;
  logic       victim_valid_o;
  logic [7:0] victim_idx_o;
  logic [1:0] victim_way_o;
  logic       busy_o;

  int checks   = 0;
  int failures = 0;

  wt_dcache_rrip_repl #(.NumSets(256), .NumWays(4)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .hit_valid_i   (hit_valid_i),
    .hit_idx_i     (hit_idx_i),
    .hit_way_i     (hit_way_i),
    .miss_valid_i  (miss_valid_i),
    .miss_ready_o  (miss_ready_o),
    .miss_idx_i    (miss_idx_i),
    .pred_result_i (pred_result_i),
    .victim_valid_o(victim_valid_o),
    .victim_idx_o  (victim_idx_o),
    .victim_way_o  (victim_way_o),
    .busy_o        (busy_o)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk_i = ~clk_i;

  // Advance one rising edge and sample 1 unit after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_hit(input int set, input int way);
    hit_valid_i = 1'b1;
    hit_idx_i   = 8'(set);
    hit_way_i   = 2'(way);
    tick();
    hit_valid_i = 1'b0;
  endtask

  // Issue one miss and return the latency from the acceptance edge to the
  // victim pulse (-1 if no pulse arrives within 12 cycles). An optional hit
  // is applied at post-acceptance edge number hit_edge.
  task automatic do_miss(input int idx, input int pred, input int hit_edge,
                         input int hit_set, input int hit_w,
                         output int lat, output int way);
    miss_valid_i  = 1'b1;
    miss_idx_i    = 8'(idx);
    pred_result_i = 2'(pred);
    tick();
    miss_valid_i = 1'b0;
    lat = -1;
    way = -1;
    for (int c = 1; c <= 12; c++) begin
      hit_valid_i = (c == hit_edge);
      hit_idx_i   = 8'(hit_set);
      hit_way_i   = 2'(hit_w);
      tick();
      hit_valid_i = 1'b0;
      if (victim_valid_o === 1'b1) begin
        lat = c;
        way = int'(victim_way_o);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) tick();
    checks++;
    if ({victim_valid_o, victim_idx_o, victim_way_o, busy_o, miss_ready_o} !== 13'b0_00000000_00_0_1) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %b expected 0_00000000_00_0_1",
               {victim_valid_o, victim_idx_o, victim_way_o, busy_o, miss_ready_o});
    end
    checks++;
    if (dut.rrpv_q[0][0] !== 2'd3 || dut.rrpv_q[255][3] !== 2'd3) begin
      failures++;
      $display("[TB] FAIL reset_rrpv: got %0d/%0d expected 3/3", dut.rrpv_q[0][0], dut.rrpv_q[255][3]);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_basic_miss();
    int lat, way;
    checks++;
    if (miss_ready_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ready_after_reset: got %b expected 1", miss_ready_o);
    end
    do_miss(5, 0, 0, 0, 0, lat, way);
    checks++;
    if (lat !== 2 || way !== 0 || victim_idx_o !== 8'd5) begin
      failures++;
      $display("[TB] FAIL basic_miss: got lat=%0d way=%0d idx=%0d expected 2/0/5", lat, way, victim_idx_o);
    end
    checks++;
    if (dut.rrpv_q[5][0] !== 2'd3) begin
      failures++;
      $display("[TB] FAIL basic_insert: got %0d expected 3", dut.rrpv_q[5][0]);
    end
    tick();
    checks++;
    if ({victim_valid_o, busy_o, victim_idx_o, victim_way_o} !== {1'b0, 1'b0, 8'd5, 2'd0}) begin
      failures++;
      $display("[TB] FAIL basic_pulse_hold: got v=%b busy=%b idx=%0d way=%0d expected 0/0/5/0",
               victim_valid_o, busy_o, victim_idx_o, victim_way_o);
    end
  endtask

  task automatic test_aging();
    int lat, way;
    logic [1:0] exp_rrpv [4] = '{2'd2, 2'd3, 2'd3, 2'd3};
    for (int w = 0; w < 4; w++) do_hit(7, w);
    checks++;
    if (dut.rrpv_q[7][3] !== 2'd0) begin
      failures++;
      $display("[TB] FAIL hit_clear: got %0d expected 0", dut.rrpv_q[7][3]);
    end
    do_miss(7, 2, 0, 0, 0, lat, way);
    checks++;
    if (lat !== 5 || way !== 0 || victim_idx_o !== 8'd7) begin
      failures++;
      $display("[TB] FAIL aging_miss: got lat=%0d way=%0d idx=%0d expected 5/0/7", lat, way, victim_idx_o);
    end
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (dut.rrpv_q[7][w] !== exp_rrpv[w]) begin
        failures++;
        $display("[TB] FAIL aging_rrpv_w%0d: got %0d expected %0d", w, dut.rrpv_q[7][w], exp_rrpv[w]);
      end
    end
    checks++;
    if (dut.rrpv_q[6][0] !== 2'd3 || dut.rrpv_q[8][1] !== 2'd3) begin
      failures++;
      $display("[TB] FAIL aging_other_sets: got %0d/%0d expected 3/3", dut.rrpv_q[6][0], dut.rrpv_q[8][1]);
    end
  endtask

  // Set 7 starts at {2,3,3,3}. Hitting ways 1..3 gives {2,0,0,0}, and one
  // miss then leaves {2,1,1,1}. In the next miss, way 0 is hit on the first
  // aging edge, so ways 1..3 must reach 3 first.
  task automatic test_hit_during_search();
    int lat, way;
    logic [1:0] exp_a [4] = '{2'd2, 2'd1, 2'd1, 2'd1};
    logic [1:0] exp_b [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    for (int w = 1; w < 4; w++) do_hit(7, w);
    do_miss(7, 2, 0, 0, 0, lat, way);
    checks++;
    if (lat !== 3 || way !== 0) begin
      failures++;
      $display("[TB] FAIL setup_miss: got lat=%0d way=%0d expected 3/0", lat, way);
    end
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (dut.rrpv_q[7][w] !== exp_a[w]) begin
        failures++;
        $display("[TB] FAIL setup_rrpv_w%0d: got %0d expected %0d", w, dut.rrpv_q[7][w], exp_a[w]);
      end
    end
    do_miss(7, 2, 1, 7, 0, lat, way);
    checks++;
    if (lat !== 4 || way !== 1) begin
      failures++;
      $display("[TB] FAIL hit_in_search: got lat=%0d way=%0d expected 4/1", lat, way);
    end
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (dut.rrpv_q[7][w] !== exp_b[w]) begin
        failures++;
        $display("[TB] FAIL hit_search_rrpv_w%0d: got %0d expected %0d", w, dut.rrpv_q[7][w], exp_b[w]);
      end
    end
  endtask

  task automatic test_collisions();
    int lat, way;
    // A hit to set 9 during the search of set 5 must not change the search.
    do_miss(5, 0, 1, 9, 0, lat, way);
    checks++;
    if (lat !== 2 || way !== 0 || dut.rrpv_q[9][0] !== 2'd0 || dut.rrpv_q[9][1] !== 2'd3) begin
      failures++;
      $display("[TB] FAIL other_set_hit: got lat=%0d way=%0d r90=%0d r91=%0d expected 2/0/0/3",
               lat, way, dut.rrpv_q[9][0], dut.rrpv_q[9][1]);
    end
    // A hit on the victim way at the insertion edge loses to the insertion.
    do_miss(5, 1, 2, 5, 0, lat, way);
    checks++;
    if (lat !== 2 || way !== 0 || dut.rrpv_q[5][0] !== 2'd2) begin
      failures++;
      $display("[TB] FAIL insert_beats_hit: got lat=%0d way=%0d rrpv=%0d expected 2/0/2",
               lat, way, dut.rrpv_q[5][0]);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    logic exp;
    checks++;
    if (miss_ready_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_ready_start: got %b expected 1", miss_ready_o);
    end
    miss_valid_i  = 1'b1;
    miss_idx_i    = 8'd20;
    pred_result_i = 2'd0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      exp = (e % 3 == 0);
      if (victim_valid_o === 1'b1) pulses++;
      checks++;
      if ({miss_ready_o, victim_valid_o} !== {exp, exp}) begin
        failures++;
        $display("[TB] FAIL b2b_cycle%0d: got ready=%b valid=%b expected %b/%b",
                 e, miss_ready_o, victim_valid_o, exp, exp);
      end
    end
    miss_valid_i = 1'b0;
    tick();
    checks++;
    if (pulses !== 3 || busy_o !== 1'b0 || victim_valid_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_pulses: got pulses=%0d busy=%b valid=%b expected 3/0/0",
               pulses, busy_o, victim_valid_o);
    end
  endtask

  task automatic test_flush();
    int lat, way, pulses = 0;
    for (int w = 0; w < 4; w++) do_hit(30, w);
    miss_valid_i  = 1'b1;
    miss_idx_i    = 8'd30;
    pred_result_i = 2'd1;
    tick();
    miss_valid_i = 1'b0;
    tick();
    checks++;
    if (busy_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_pre_busy: got %b expected 1", busy_o);
    end
    flush_i     = 1'b1;
    hit_valid_i = 1'b1;
    hit_idx_i   = 8'd40;
    hit_way_i   = 2'd1;
    tick();
    flush_i     = 1'b0;
    hit_valid_i = 1'b0;
    checks++;
    if ({busy_o, miss_ready_o, victim_valid_o} !== 3'b010) begin
      failures++;
      $display("[TB] FAIL flush_state: got %b expected 010", {busy_o, miss_ready_o, victim_valid_o});
    end
    checks++;
    if (dut.rrpv_q[30][0] !== 2'd3 || dut.rrpv_q[40][1] !== 2'd3 || dut.rrpv_q[7][0] !== 2'd3) begin
      failures++;
      $display("[TB] FAIL flush_rrpv: got %0d/%0d/%0d expected 3/3/3",
               dut.rrpv_q[30][0], dut.rrpv_q[40][1], dut.rrpv_q[7][0]);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      if (victim_valid_o === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("[TB] FAIL flush_no_pulse: got %0d expected 0", pulses);
    end
    do_miss(30, 1, 0, 0, 0, lat, way);
    checks++;
    if (lat !== 2 || way !== 0) begin
      failures++;
      $display("[TB] FAIL flush_miss30: got lat=%0d way=%0d expected 2/0", lat, way);
    end
    do_miss(7, 1, 0, 0, 0, lat, way);
    checks++;
    if (lat !== 2 || way !== 0 || victim_idx_o !== 8'd7) begin
      failures++;
      $display("[TB] FAIL flush_miss7: got lat=%0d way=%0d idx=%0d expected 2/0/7", lat, way, victim_idx_o);
    end
  endtask

  task automatic test_reset_mid_search();
    int lat, way, pulses = 0;
    for (int w = 0; w < 4; w++) do_hit(50, w);
    miss_valid_i  = 1'b1;
    miss_idx_i    = 8'd50;
    pred_result_i = 2'd0;
    tick();
    miss_valid_i = 1'b0;
    tick();
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if ({victim_valid_o, victim_idx_o, victim_way_o, busy_o, miss_ready_o} !== 13'b0_00000000_00_0_1) begin
      failures++;
      $display("[TB] FAIL async_reset_outputs: got %b expected 0_00000000_00_0_1",
               {victim_valid_o, victim_idx_o, victim_way_o, busy_o, miss_ready_o});
    end
    checks++;
    if (dut.rrpv_q[50][0] !== 2'd3 || dut.rrpv_q[5][0] !== 2'd3 || dut.rrpv_q[7][1] !== 2'd3) begin
      failures++;
      $display("[TB] FAIL async_reset_rrpv: got %0d/%0d/%0d expected 3/3/3",
               dut.rrpv_q[50][0], dut.rrpv_q[5][0], dut.rrpv_q[7][1]);
    end
    tick();
    rst_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (victim_valid_o === 1'b1 || busy_o === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("[TB] FAIL post_reset_quiet: got %0d active cycles expected 0", pulses);
    end
    do_miss(50, 0, 0, 0, 0, lat, way);
    checks++;
    if (lat !== 2 || way !== 0) begin
      failures++;
      $display("[TB] FAIL post_reset_miss: got lat=%0d way=%0d expected 2/0", lat, way);
    end
  endtask

  // Watchdog: stop the run if a scenario stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Run the scenarios in order, then print the summary line.
  initial begin
    rst_i         = 1'b1;
    flush_i       = 1'b0;
    hit_valid_i   = 1'b0;
    hit_idx_i     = '0;
    hit_way_i     = '0;
    miss_valid_i  = 1'b0;
    miss_idx_i    = '0;
    pred_result_i = '0;
    test_reset();
    test_basic_miss();
    test_aging();
    test_hit_during_search();
    test_collisions();
    test_back_to_back();
    test_flush();
    test_reset_mid_search();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
